// File: rtl/ras_ckpt_buf_if.sv
// Checkpoint buffer bus: allocate / resolve / retire / flush requests and the
// recovery view of the oldest checkpoint that is fed back to the RAS.
interface ras_ckpt_buf_if #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned PTR_W = 4,
    parameter int unsigned PC_W  = 64
);
    logic             alloc_vld_i;
    logic [PTR_W-1:0] alloc_ras_ptr_i;
    logic [PC_W-1:0]  alloc_pc_i;
    logic             alloc_rdy_o;
    logic [IDX_W-1:0] alloc_tag_o;
    logic             resolve_vld_i;
    logic [IDX_W-1:0] resolve_tag_i;
    logic             resolve_mispred_i;
    logic             retire_vld_i;
    logic             flush_rt_i;
    logic             bob_vld_o;
    logic [PTR_W-1:0] ras_ptr_rt_o;
    logic [PC_W-1:0]  head_pc_o;
    logic             head_mispred_o;
    logic [IDX_W:0]   count_o;
    logic             overflow_err_o;

    modport master (
        output alloc_vld_i, alloc_ras_ptr_i, alloc_pc_i,
        output resolve_vld_i, resolve_tag_i, resolve_mispred_i,
        output retire_vld_i, flush_rt_i,
        input  alloc_rdy_o, alloc_tag_o, bob_vld_o, ras_ptr_rt_o,
        input  head_pc_o, head_mispred_o, count_o, overflow_err_o
    );

    modport slave (
        input  alloc_vld_i, alloc_ras_ptr_i, alloc_pc_i,
        input  resolve_vld_i, resolve_tag_i, resolve_mispred_i,
        input  retire_vld_i, flush_rt_i,
        output alloc_rdy_o, alloc_tag_o, bob_vld_o, ras_ptr_rt_o,
        output head_pc_o, head_mispred_o, count_o, overflow_err_o
    );
endinterface

// File: rtl/ras_ckpt_buf.sv
// Branch checkpoint buffer: circular FIFO of RAS pointer checkpoints with
// out-of-order resolve marking, in-order retire and retire-stage flush.
module ras_ckpt_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned PTR_W = 4,
    parameter int unsigned PC_W  = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    ras_ckpt_buf_if.slave bus
);
    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [IDX_W:0]   head;
    logic [IDX_W:0]   tail;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] res;
    logic [DEPTH-1:0] mis;
    logic [PTR_W-1:0] ptr_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic             ovf;

    logic [IDX_W-1:0] hidx;
    logic [IDX_W-1:0] tidx;
    logic             empty;
    logic             full;
    logic             do_alloc;
    logic             do_retire;

    assign hidx  = head[IDX_W-1:0];
    assign tidx  = tail[IDX_W-1:0];
    assign empty = (head == tail);
    assign full  = (hidx == tidx) && (head[IDX_W] != tail[IDX_W]);

    assign do_alloc  = bus.alloc_vld_i && !full && !bus.flush_rt_i;
    assign do_retire = bus.retire_vld_i && !empty && res[hidx] && !bus.flush_rt_i;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            vld  <= '0;
            res  <= '0;
            mis  <= '0;
            ovf  <= 1'b0;
        end else if (bus.flush_rt_i) begin
            vld  <= '0;
            head <= tail;
        end else begin
            if (bus.alloc_vld_i && full)
                ovf <= 1'b1;
            if (bus.resolve_vld_i && vld[bus.resolve_tag_i]) begin
                res[bus.resolve_tag_i] <= 1'b1;
                mis[bus.resolve_tag_i] <= bus.resolve_mispred_i;
            end
            // retire and alloc never hit the same slot: alloc is blocked when full
            if (do_retire) begin
                vld[hidx] <= 1'b0;
                head      <= head + PTR_ONE;
            end
            if (do_alloc) begin
                vld[tidx] <= 1'b1;
                res[tidx] <= 1'b0;
                mis[tidx] <= 1'b0;
                tail      <= tail + PTR_ONE;
            end
        end
    end

    // Payload needs no reset: it is only observed behind a valid head.
    always_ff @(posedge clock) begin
        if (do_alloc) begin
            ptr_mem[tidx] <= bus.alloc_ras_ptr_i;
            pc_mem[tidx]  <= bus.alloc_pc_i;
        end
    end

    assign bus.alloc_rdy_o    = !full;
    assign bus.alloc_tag_o    = tidx;
    assign bus.bob_vld_o      = !empty;
    assign bus.ras_ptr_rt_o   = empty ? '0 : ptr_mem[hidx];
    assign bus.head_pc_o      = empty ? '0 : pc_mem[hidx];
    assign bus.head_mispred_o = !empty && res[hidx] && mis[hidx];
    assign bus.count_o        = tail - head;
    assign bus.overflow_err_o = ovf;
endmodule

// File: tb/tb_ras_ckpt_buf.sv
// Directed vector bench for ras_ckpt_buf: table of one-cycle stimuli with
// hand-computed post-edge outputs, plus a same-cycle flush/alloc sequence.
module tb_ras_ckpt_buf;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clock = ~clock;

    ras_ckpt_buf_if #(.IDX_W(4), .PTR_W(4), .PC_W(64)) bus ();

    ras_ckpt_buf #(.DEPTH(16), .IDX_W(4), .PTR_W(4), .PC_W(64)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic       rst;
        logic       av;
        logic [3:0] ap;
        logic       rv;
        logic [3:0] rt;
        logic       rm;
        logic       ret;
        logic       fl;
        logic [4:0] c;
        logic       bv;
        logic [3:0] p;
        logic       hm;
        logic       rdy;
        logic [3:0] tag;
        logic       ovf;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];

    function automatic vec_t mk(input logic rst, input logic av, input logic [3:0] ap,
                                input logic rv, input logic [3:0] rt, input logic rm,
                                input logic ret, input logic fl,
                                input logic [4:0] c, input logic bv, input logic [3:0] p,
                                input logic hm, input logic rdy, input logic [3:0] tag,
                                input logic ovf);
        vec_t v;
        v.rst = rst; v.av = av; v.ap = ap; v.rv = rv; v.rt = rt; v.rm = rm;
        v.ret = ret; v.fl = fl; v.c = c; v.bv = bv; v.p = p; v.hm = hm;
        v.rdy = rdy; v.tag = tag; v.ovf = ovf;
        return v;
    endfunction

    function automatic logic [63:0] pc_of(input logic [3:0] p);
        return 64'hA000_0000_0000_0000 | {56'd0, p, 4'h4};
    endfunction

    task automatic cmp(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset_n               = ~v.rst;
        bus.alloc_vld_i       = v.av;
        bus.alloc_ras_ptr_i   = v.ap;
        bus.alloc_pc_i        = pc_of(v.ap);
        bus.resolve_vld_i     = v.rv;
        bus.resolve_tag_i     = v.rt;
        bus.resolve_mispred_i = v.rm;
        bus.retire_vld_i      = v.ret;
        bus.flush_rt_i        = v.fl;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clock);
        drive(v);
        @(posedge clock);
        #1;
        nvec++;
        cmp("count",   idx, 64'(bus.count_o),        64'(v.c));
        cmp("bob_vld", idx, 64'(bus.bob_vld_o),      64'(v.bv));
        cmp("ras_ptr", idx, 64'(bus.ras_ptr_rt_o),   64'(v.p));
        cmp("head_pc", idx, bus.head_pc_o,           v.bv ? pc_of(v.p) : 64'd0);
        cmp("mispred", idx, 64'(bus.head_mispred_o), 64'(v.hm));
        cmp("rdy",     idx, 64'(bus.alloc_rdy_o),    64'(v.rdy));
        cmp("tag",     idx, 64'(bus.alloc_tag_o),    64'(v.tag));
        cmp("ovf",     idx, 64'(bus.overflow_err_o), 64'(v.ovf));
    endtask

    // shorthand: alloc / resolve / retire / flush / reset vectors
    function automatic vec_t va_(input logic [3:0] ap, input logic [4:0] c, input logic [3:0] p,
                                 input logic rdy, input logic [3:0] tag, input logic ovf);
        return mk(1'b0, 1'b1, ap, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, c, 1'b1, p, 1'b0, rdy, tag, ovf);
    endfunction

    function automatic vec_t vr_(input logic [3:0] rt, input logic rm, input logic [4:0] c,
                                 input logic [3:0] p, input logic hm, input logic rdy,
                                 input logic [3:0] tag, input logic ovf);
        return mk(1'b0, 1'b0, 4'd0, 1'b1, rt, rm, 1'b0, 1'b0, c, 1'b1, p, hm, rdy, tag, ovf);
    endfunction

    function automatic vec_t vt_(input logic [4:0] c, input logic bv, input logic [3:0] p,
                                 input logic hm, input logic [3:0] tag, input logic ovf);
        return mk(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, c, bv, p, hm, 1'b1, tag, ovf);
    endfunction

    initial begin
        drive(mk(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0,
                 5'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0));

        // reset, three allocs, out-of-order resolve, blocked and normal retire
        va.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0,
                        5'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0));
        va.push_back(va_(4'd5, 5'd1, 4'd5, 1'b1, 4'd1, 1'b0));
        va.push_back(va_(4'd6, 5'd2, 4'd5, 1'b1, 4'd2, 1'b0));
        va.push_back(va_(4'd7, 5'd3, 4'd5, 1'b1, 4'd3, 1'b0));
        va.push_back(vr_(4'd1, 1'b0, 5'd3, 4'd5, 1'b0, 1'b1, 4'd3, 1'b0));
        va.push_back(vt_(5'd3, 1'b1, 4'd5, 1'b0, 4'd3, 1'b0));
        va.push_back(vr_(4'd0, 1'b1, 5'd3, 4'd5, 1'b1, 1'b1, 4'd3, 1'b0));
        va.push_back(vt_(5'd2, 1'b1, 4'd6, 1'b0, 4'd3, 1'b0));
        va.push_back(vt_(5'd1, 1'b1, 4'd7, 1'b0, 4'd3, 1'b0));
        // fill to 16 entries; tag wraps 15 -> 0
        for (int i = 0; i < 15; i++)
            va.push_back(va_(4'(8 + i), 5'(2 + i), 4'd7, (i == 14) ? 1'b0 : 1'b1,
                             4'(4 + i), 1'b0));
        va.push_back(va_(4'd3, 5'd16, 4'd7, 1'b0, 4'd2, 1'b1));
        va.push_back(vr_(4'd2, 1'b0, 5'd16, 4'd7, 1'b0, 1'b0, 4'd2, 1'b1));
        // alloc + retire while full: alloc dropped, retire applies
        va.push_back(mk(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0,
                        5'd15, 1'b1, 4'd8, 1'b0, 1'b1, 4'd2, 1'b1));
        va.push_back(va_(4'd3, 5'd16, 4'd8, 1'b0, 4'd3, 1'b1));
        // flush with alloc from full; overflow stays sticky
        va.push_back(mk(1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1,
                        5'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1));
        va.push_back(va_(4'd9,  5'd1, 4'd9, 1'b1, 4'd4, 1'b1));
        va.push_back(va_(4'd10, 5'd2, 4'd9, 1'b1, 4'd5, 1'b1));
        va.push_back(va_(4'd11, 5'd3, 4'd9, 1'b1, 4'd6, 1'b1));
        va.push_back(va_(4'd12, 5'd4, 4'd9, 1'b1, 4'd7, 1'b1));

        // after the hand flush: build to 5 entries, alloc+retire at count 5
        vb.push_back(va_(4'd2, 5'd1, 4'd2, 1'b1, 4'd8,  1'b1));
        vb.push_back(va_(4'd3, 5'd2, 4'd2, 1'b1, 4'd9,  1'b1));
        vb.push_back(va_(4'd4, 5'd3, 4'd2, 1'b1, 4'd10, 1'b1));
        vb.push_back(va_(4'd5, 5'd4, 4'd2, 1'b1, 4'd11, 1'b1));
        vb.push_back(va_(4'd6, 5'd5, 4'd2, 1'b1, 4'd12, 1'b1));
        vb.push_back(vr_(4'd7, 1'b1, 5'd5, 4'd2, 1'b1, 1'b1, 4'd12, 1'b1));
        vb.push_back(mk(1'b0, 1'b1, 4'd13, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0,
                        5'd5, 1'b1, 4'd3, 1'b0, 1'b1, 4'd13, 1'b1));
        for (int i = 0; i < 4; i++)
            vb.push_back(vr_(4'(8 + i), 1'b0, 5'd5, 4'd3, 1'b0, 1'b1, 4'd13, 1'b1));
        vb.push_back(vt_(5'd4, 1'b1, 4'd4,  1'b0, 4'd13, 1'b1));
        vb.push_back(vt_(5'd3, 1'b1, 4'd5,  1'b0, 4'd13, 1'b1));
        vb.push_back(vt_(5'd2, 1'b1, 4'd6,  1'b0, 4'd13, 1'b1));
        vb.push_back(vt_(5'd1, 1'b1, 4'd13, 1'b0, 4'd13, 1'b1));
        vb.push_back(vt_(5'd1, 1'b1, 4'd13, 1'b0, 4'd13, 1'b1));
        vb.push_back(vr_(4'd12, 1'b1, 5'd1, 4'd13, 1'b1, 1'b1, 4'd13, 1'b1));
        vb.push_back(vr_(4'd12, 1'b0, 5'd1, 4'd13, 1'b0, 1'b1, 4'd13, 1'b1));
        vb.push_back(vr_(4'd0,  1'b1, 5'd1, 4'd13, 1'b0, 1'b1, 4'd13, 1'b1));
        vb.push_back(vt_(5'd0, 1'b0, 4'd0, 1'b0, 4'd13, 1'b1));
        vb.push_back(vt_(5'd0, 1'b0, 4'd0, 1'b0, 4'd13, 1'b1));
        // 10 entries, then reset with a concurrent alloc
        for (int i = 0; i < 10; i++)
            vb.push_back(va_(4'(i), 5'(i + 1), 4'd0, 1'b1, 4'(14 + i), 1'b1));
        vb.push_back(mk(1'b1, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0,
                        5'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0));
        vb.push_back(va_(4'd4, 5'd1, 4'd4, 1'b1, 4'd1, 1'b0));

        foreach (va[i]) apply(va[i], i);

        // flush with a concurrent alloc: pre-edge view still shows the old head
        @(negedge clock);
        drive(mk(1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1,
                 5'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0));
        #1;
        nvec++;
        cmp("flush_pre_bv",  900, 64'(bus.bob_vld_o),    64'd1);
        cmp("flush_pre_ptr", 900, 64'(bus.ras_ptr_rt_o), 64'd9);
        cmp("flush_pre_pc",  900, bus.head_pc_o,         pc_of(4'd9));
        cmp("flush_pre_cnt", 900, 64'(bus.count_o),      64'd4);
        @(posedge clock);
        #1;
        nvec++;
        cmp("flush_post_cnt", 901, 64'(bus.count_o),   64'd0);
        cmp("flush_post_bv",  901, 64'(bus.bob_vld_o), 64'd0);
        cmp("flush_post_tag", 901, 64'(bus.alloc_tag_o), 64'd7);

        foreach (vb[i]) apply(vb[i], 1000 + i);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
